dual_port_ram: RTL
==================

// Module: dual_port_ram
// PURPOSE
//  Parametrised simple dual-port RAM (1 write port, 1 read port); next generation of the single-port RAM.
//  Adds byte-enable writes, configurable read latency, defined read-during-write behaviour,
//  automatic zero-clear after reset, and out-of-range address detection.
//  Used as a scratch or buffer memory behind datapath blocks; the read and write ports run concurrently.
// PARAMETERS
//  WIDTH        32  data width in bits; must be a multiple of 8
//  DEPTH        16  number of words; need not be a power of two
//  READ_LATENCY 1   clock edges from rd_en sampled to rd_valid; legal values 1 or 2
//  RDW_MODE     0   same-address read/write in one cycle: 0 = READ_FIRST (old data), 1 = WRITE_FIRST (new data)
//  Derived: ADDR_W = (DEPTH>1) ? $clog2(DEPTH) : 1, BE_W = WIDTH/8
// PORTS
//  clock       in   1       single clock; all state updates on posedge
//  reset       in   1       asynchronous, active-high reset
//  wr_en       in   1       write request
//  wr_addr     in   ADDR_W  write address
//  wr_data     in   WIDTH   write data
//  wr_be       in   BE_W    byte enables; bit i enables wr_data[8i+7:8i]
//  rd_en       in   1       read request
//  rd_addr     in   ADDR_W  read address
//  rd_data     out  WIDTH   read data; qualified by rd_valid
//  rd_valid    out  1       one-cycle pulse per accepted read
//  init_busy   out  1       high while the post-reset clear sweep runs
//  drop_err    out  1       one-cycle pulse: request arrived while init_busy=1 and was discarded
//  addr_err    out  1       one-cycle pulse: wr_addr or rd_addr >= DEPTH on an active request
// BEHAVIOUR
//  - Reset (async assert): rd_data=0, rd_valid=0, init_busy=1, drop_err=0, addr_err=0, read pipeline flushed, clear ptr=0, FSM=CLEAR.
//  - FSM CLEAR: each posedge after reset release writes 0 to mem[ptr], then ptr++.
//    On the edge that writes DEPTH-1, FSM moves to READY. init_busy is low after exactly DEPTH edges.
//  - In CLEAR, wr_en/rd_en are ignored. drop_err pulses on the next edge if either was high. No rd_valid is produced.
//  - READY write: if wr_en and wr_addr<DEPTH, update only the bytes whose wr_be bit is 1. wr_be=0 is a legal no-op.
//  - READY read: rd_en with rd_addr<DEPTH is accepted on edge N. rd_valid=1 and rd_data are presented after edge N+READ_LATENCY-1.
//    This means they are visible in the cycle following the READ_LATENCY-th edge.
//    Back-to-back reads are allowed every cycle; throughput is 1 per clock.
//  - rd_data holds its last value while rd_valid=0.
//  - Same-cycle wr/rd to the same address:
//    - READ_FIRST: rd_data returns the pre-write word.
//    - WRITE_FIRST: rd_data returns the old word merged with the enabled new bytes.
//  - Out of range (addr>=DEPTH): the write is suppressed. The read is still accepted and returns rd_data=0 with rd_valid.
//    addr_err pulses on the next edge; it is one pulse even if both ports are out of range.
//  - Reset mid-operation: in-flight reads are lost (no rd_valid), memory is re-cleared from address 0, and FSM returns to CLEAR.
//  - Write and read ports are independent. A write and read to different addresses in the same cycle both complete.
// TESTING  (WIDTH=32, DEPTH=16 unless noted)
//  1. Release reset, idle: init_busy high 16 edges then low; reads of addr 0..15 -> rd_data=0, one rd_valid per read.
//  2. wr 0xDEADBEEF@3 be=F, then wr 0x11223344@3 be=0101b, then read@3:
//     -> rd_data 0xDE22BE44 after READ_LATENCY (check with 1 and 2).
//  3. Same cycle wr 0xA5A5A5A5@7 be=F and rd@7 (mem[7]=0x01234567):
//     -> READ_FIRST 0x01234567, WRITE_FIRST 0xA5A5A5A5; next read@7 -> 0xA5A5A5A5.
//  4. DEPTH=12: wr 0xFFFFFFFF@13 then rd@13 -> addr_err pulses each time, rd_data=0 with rd_valid, mem[0..11] unchanged.
//  5. wr_en/rd_en held during CLEAR -> drop_err pulses each cycle, no rd_valid, memory all zero after init.
//  6. Streaming rd@0..15 every cycle, assert reset mid-stream -> rd_valid stops immediately, init_busy reasserts, reads after re-init return 0.

Source files
------------

// File: rtl/dual_port_ram_if.sv
// Bus bundle for the dual_port_ram.
// The write port (wr_*), the read request (rd_en, rd_addr) and all status
// returns (rd_data, rd_valid, init_busy, drop_err, addr_err) travel together.
//   master : the client that issues writes and reads
//   slave  : the memory itself
interface dual_port_ram_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BE_W   = WIDTH / 8;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [BE_W-1:0]   wr_be;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              init_busy;
    logic              drop_err;
    logic              addr_err;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  rd_data, rd_valid, init_busy, drop_err, addr_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output rd_data, rd_valid, init_busy, drop_err, addr_err
    );
endinterface

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: one byte-enabled write port and one read port running
// concurrently. After reset an internal sweep writes zero to every word
// (init_busy high); requests arriving during the sweep are discarded and
// flagged on drop_err. Reads complete READ_LATENCY edges after acceptance,
// out-of-range addresses are flagged on addr_err (writes suppressed, reads
// return zero), and RDW_MODE selects old (0) or merged new (1) data when the
// read and write ports hit the same word in the same cycle.
// Ports:
//   clock : single clock, all state on posedge
//   reset : asynchronous, active-high
//   bus   : dual_port_ram_if slave modport (requests in, read data/status out)
module dual_port_ram #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 16,
    parameter int READ_LATENCY = 1,
    parameter int RDW_MODE     = 0
) (
    input  logic           clock,
    input  logic           reset,
    dual_port_ram_if.slave bus
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BE_W   = WIDTH / 8;
    // One extra bit so DEPTH itself is representable for range compares.
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic              clearing;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic              ready;
    logic              wr_in_range, rd_in_range;
    logic              wr_ok, rd_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [WIDTH-1:0]  rd_word;
    logic [WIDTH-1:0]  rd_merged;
    logic              same_word;

    logic              s1_valid_reg;
    logic [WIDTH-1:0]  s1_data_reg;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic              drop_err_reg, addr_err_reg;

    // ---------------- clear-sweep FSM ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_CLEAR;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        clearing   = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                clearing = 1'b1;
                if (ptr_reg == LAST_ADDR) begin
                    state_next = ST_READY;
                    ptr_next   = '0;
                end else begin
                    ptr_next = ptr_reg + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------- request qualification ----------------
    assign ready       = (state_reg == ST_READY);
    assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_C);
    assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_C);
    assign wr_ok       = ready && bus.wr_en && wr_in_range;
    // Out-of-range reads are still accepted; they just return zero.
    assign rd_ok       = ready && bus.rd_en;

    // ---------------- write port (shared with the clear sweep) ----------------
    assign mem_we    = clearing || wr_ok;
    assign mem_waddr = clearing ? ptr_reg : bus.wr_addr;
    assign mem_wdata = clearing ? '0 : bus.wr_data;
    assign mem_be    = clearing ? '1 : bus.wr_be;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (mem_be[b]) begin
                    mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // ---------------- read port ----------------
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[bus.rd_addr];
        end
    end

    // wr_ok implies the write address is in range, so a match also implies
    // the read address is in range.
    assign same_word = (RDW_MODE == 1) && wr_ok && (bus.wr_addr == bus.rd_addr);

    // Write-first bypass: enabled bytes of the incoming write replace the
    // stored bytes on their way into the read pipeline.
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_rdw
        assign rd_merged[8*gi +: 8] = (same_word && bus.wr_be[gi]) ?
                                      bus.wr_data[8*gi +: 8] : rd_word[8*gi +: 8];
    end

    // Data registers only load with a valid read so rd_data holds otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= '0;
        end else begin
            s1_valid_reg <= rd_ok;
            if (rd_ok) begin
                s1_data_reg <= rd_merged;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic             rd_valid_reg;
        logic [WIDTH-1:0] rd_data_reg;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                rd_valid_reg <= 1'b0;
                rd_data_reg  <= '0;
            end else begin
                rd_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    rd_data_reg <= s1_data_reg;
                end
            end
        end

        assign out_valid = rd_valid_reg;
        assign out_data  = rd_data_reg;
    end else begin : g_lat1
        assign out_valid = s1_valid_reg;
        assign out_data  = s1_data_reg;
    end

    // ---------------- status pulses ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_err_reg <= 1'b0;
            addr_err_reg <= 1'b0;
        end else begin
            drop_err_reg <= clearing && (bus.wr_en || bus.rd_en);
            // A single pulse covers both ports being out of range together.
            addr_err_reg <= ready && ((bus.wr_en && !wr_in_range) ||
                                      (bus.rd_en && !rd_in_range));
        end
    end

    assign bus.rd_valid  = out_valid;
    assign bus.rd_data   = out_data;
    assign bus.init_busy = clearing;
    assign bus.drop_err  = drop_err_reg;
    assign bus.addr_err  = addr_err_reg;
endmodule
